// File: rtl/arbitro_mem_pkg.sv
// Shared constants for the unified instruction/data RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state encoding, requester IDs, and a helper that
// returns the opposite requester for the round-robin tie-break.
package arbitro_mem_pkg;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONCEDE   = 2'd1,
        RESPUESTA = 2'd2
    } estado_arb_t;

    localparam logic ID_CORE     = 1'b0;
    localparam logic ID_CARGADOR = 1'b1;

    function automatic logic otro_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin pick between the core and the loader.
// Latency: purely combinational.
// Backpressure: none; the caller only samples the pick while idle.
//
// Ports:
//   req_core, req_cargador : raw requests (already masked by any blocking)
//   ultimo                 : ID of the requester served last
//   gnt_vld                : at least one request is present
//   gnt_id                 : chosen requester (opposite of ultimo on a tie)
module arbitro_rr2
    import arbitro_mem_pkg::*;
(
    input  logic req_core,
    input  logic req_cargador,
    input  logic ultimo,
    output logic gnt_vld,
    output logic gnt_id
);

    always_comb begin
        gnt_vld = req_core | req_cargador;
        gnt_id  = ID_CORE;
        if (req_core && req_cargador) begin
            gnt_id = otro_id(ultimo);
        end else if (req_cargador) begin
            gnt_id = ID_CARGADOR;
        end
    end

endmodule

// File: rtl/arbitro_mem.sv
// Arbitrates the unified RAM between the RV32I core and the program loader.
// Latency: grant to listo is 2 cycles; one access every 3 cycles per requester.
// Backpressure: req/listo handshake; a requester stalls until its listo pulse.
//
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   core_req/we/dir/dat_esc           : core access request
//   core_listo, core_dat_lec          : core completion pulse and read data
//   cargador_req/we/dir/dat_esc       : loader access request
//   cargador_listo, cargador_dat_lec  : loader completion pulse and read data
//   mem_dir, mem_dat_esc, mem_esc     : RAM address, write data, write enable
//   mem_dat_lec                       : RAM read data, one cycle after address
//   ocupado                           : arbiter is not in REPOSO
// Optional feature ARB_BLOQUEO_EN adds cargador_bloqueo, which keeps the core
// from being granted while set; accesses already granted still complete.
module arbitro_mem
    import arbitro_mem_pkg::*;
#(
    parameter int ANCHO_DIR = 10,
    parameter int ANCHO_DAT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [ANCHO_DIR-1:0] core_dir,
    input  logic [ANCHO_DAT-1:0] core_dat_esc,
    output logic                 core_listo,
    output logic [ANCHO_DAT-1:0] core_dat_lec,
    input  logic                 cargador_req,
    input  logic                 cargador_we,
    input  logic [ANCHO_DIR-1:0] cargador_dir,
    input  logic [ANCHO_DAT-1:0] cargador_dat_esc,
    output logic                 cargador_listo,
    output logic [ANCHO_DAT-1:0] cargador_dat_lec,
    output logic [ANCHO_DIR-1:0] mem_dir,
    output logic [ANCHO_DAT-1:0] mem_dat_esc,
    output logic                 mem_esc,
    input  logic [ANCHO_DAT-1:0] mem_dat_lec,
    output logic                 ocupado
`ifdef ARB_BLOQUEO_EN
    ,
    input  logic                 cargador_bloqueo
`endif
);

    estado_arb_t estado, estado_sig;
    logic        concesion, concesion_sig;
    logic        ultimo_servido;
    logic        core_pide;
    logic        rr_vld;
    logic        rr_id;

`ifdef ARB_BLOQUEO_EN
    // Blocking only masks new grants; an access already past REPOSO finishes.
    assign core_pide = core_req & ~cargador_bloqueo;
`else
    assign core_pide = core_req;
`endif

    arbitro_rr2 u_rr2 (
        .req_core     (core_pide),
        .req_cargador (cargador_req),
        .ultimo       (ultimo_servido),
        .gnt_vld      (rr_vld),
        .gnt_id       (rr_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado         <= REPOSO;
            concesion      <= ID_CORE;
            // Starting from "loader served last" lets the core win the first tie.
            ultimo_servido <= ID_CARGADOR;
        end else begin
            estado    <= estado_sig;
            concesion <= concesion_sig;
            if (estado == RESPUESTA) begin
                ultimo_servido <= concesion;
            end
        end
    end

    always_comb begin
        estado_sig       = estado;
        concesion_sig    = concesion;
        mem_dir          = '0;
        mem_dat_esc      = '0;
        mem_esc          = 1'b0;
        core_listo       = 1'b0;
        core_dat_lec     = '0;
        cargador_listo   = 1'b0;
        cargador_dat_lec = '0;
        ocupado          = 1'b0;

        case (estado)
            REPOSO: begin
                if (rr_vld) begin
                    concesion_sig = rr_id;
                    estado_sig    = CONCEDE;
                end
            end
            CONCEDE: begin
                estado_sig = RESPUESTA;
                if (concesion == ID_CORE) begin
                    mem_dir     = core_dir;
                    mem_dat_esc = core_dat_esc;
                    mem_esc     = core_we;
                end else begin
                    mem_dir     = cargador_dir;
                    mem_dat_esc = cargador_dat_esc;
                    mem_esc     = cargador_we;
                end
            end
            RESPUESTA: begin
                // Requesters drop req only after listo, so never re-grant here.
                estado_sig = REPOSO;
                if (concesion == ID_CORE) begin
                    core_listo   = 1'b1;
                    core_dat_lec = mem_dat_lec;
                end else begin
                    cargador_listo   = 1'b1;
                    cargador_dat_lec = mem_dat_lec;
                end
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase

        ocupado = (estado != REPOSO);

        // Outputs are forced quiet while reset is held so an aborted write
        // never reaches the RAM on the reset edge.
        if (reset) begin
            mem_dir          = '0;
            mem_dat_esc      = '0;
            mem_esc          = 1'b0;
            core_listo       = 1'b0;
            core_dat_lec     = '0;
            cargador_listo   = 1'b0;
            cargador_dat_lec = '0;
            ocupado          = 1'b0;
        end
    end

endmodule

// File: doc/arbitro_mem.md
Name: arbitro_mem

Overview:
Arbitrates the single unified instruction/data RAM between two requesters.
- Requester 0: the multicycle RV32I core. It issues fetch, load and store accesses.
- Requester 1: the program loader, which writes program images and reads them back.
- Sits between both requesters and the synchronous-read RAM. Each access is an explicit req/listo handshake, so the core's control sequencer is stalled while the loader owns the memory.

Parameters:
ANCHO_DIR, 10, word-address width of the RAM
ANCHO_DAT, 32, data width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
core_req  input  1  core access request; held until core_listo
core_we  input  1  1 = write, 0 = read
core_dir  input  ANCHO_DIR  core word address
core_dat_esc  input  ANCHO_DAT  core write data
core_listo  output  1  one-cycle completion pulse to the core
core_dat_lec  output  ANCHO_DAT  read data; valid only while core_listo=1
cargador_req  input  1  loader access request; held until cargador_listo
cargador_we  input  1  1 = write, 0 = read
cargador_dir  input  ANCHO_DIR  loader word address
cargador_dat_esc  input  ANCHO_DAT  loader write data
cargador_listo  output  1  one-cycle completion pulse to the loader
cargador_dat_lec  output  ANCHO_DAT  read data; valid only while cargador_listo=1
mem_dir  output  ANCHO_DIR  RAM address
mem_dat_esc  output  ANCHO_DAT  RAM write data
mem_esc  output  1  RAM write enable
mem_dat_lec  input  ANCHO_DAT  RAM read data, one cycle after address
ocupado  output  1  high in any state other than REPOSO

Behaviour:
- Reset is synchronous on clk and active-high. During reset:
  - state goes to REPOSO;
  - registered grant goes to core; ultimo_servido goes to cargador, so the core wins the first tie;
  - all outputs are 0, including mem_dir, mem_dat_esc, core_dat_lec and cargador_dat_lec.
- Reset mid-access aborts the access. mem_esc is 0 from the first post-reset cycle and no listo is issued.
- FSM states: REPOSO, CONCEDE, RESPUESTA.
- REPOSO:
  - With no request, stay in REPOSO.
  - With exactly one request, grant that requester and go to CONCEDE.
  - With both requesting, grant the requester opposite ultimo_servido (round-robin).
- CONCEDE (1 cycle):
  - mem_dir, mem_dat_esc and mem_esc are driven from the granted requester's inputs.
  - mem_esc = granted we. It is 0 in every other state.
  - Next state is RESPUESTA.
- RESPUESTA (1 cycle):
  - The granted requester's listo = 1.
  - Its dat_lec = mem_dat_lec. Reads are valid here; for writes the data is don't-care.
  - ultimo_servido is updated to the granted requester.
  - Next state is always REPOSO, because the requester deasserts req only after seeing listo.
- Latency:
  - An access completes 2 cycles after it is granted. Minimum request-to-listo is 2 cycles (req seen in REPOSO).
  - Back-to-back accesses from one requester cost 3 cycles each.
  - A waiting requester waits at most one foreign access, i.e. 3 extra cycles.
- Outside CONCEDE, mem_dir and mem_dat_esc are 0. Outside RESPUESTA, both listo outputs and both dat_lec outputs are 0.
- Address and write data are sampled combinationally in CONCEDE. Requesters must hold them stable from req until listo.
- If req drops before listo, the access still completes and the listo pulse is still issued. The requester ignores it.
- Only one listo is ever high in a cycle. listo never asserts for a requester that was not granted.
- No address wrap logic: addresses pass through unmodified at ANCHO_DIR bits.

Optional Feature:
ARB_BLOQUEO_EN
- Defined: adds input port cargador_bloqueo (1 bit).
  - While cargador_bloqueo=1, core_req is never granted from REPOSO and the core stays stalled with no listo.
  - An access to the core that is already in CONCEDE or RESPUESTA completes normally.
  - The loader is granted whenever it requests.
  - When cargador_bloqueo falls, normal round-robin resumes.
- Not defined: port absent; pure round-robin as above.

Decomposition:
- Shared package (next to the control sequencer's state constants):
  - state encodings REPOSO=0, CONCEDE=1, RESPUESTA=2 (2 bits);
  - requester IDs ID_CORE=0, ID_CARGADOR=1.
- No sub-module is needed. The grant decision, a combinational round-robin pick of the two requesters, may be split out as arbitro_rr2 if reused.

Test Plan:
- Core read only: core_req=1, core_we=0, core_dir=0x010, RAM[0x010]=0x00500093. Expect mem_dir=0x010 in CONCEDE, then core_listo=1 and core_dat_lec=0x00500093 exactly 2 cycles after grant; cargador_listo stays 0.
- Loader write then core read of the same word: cargador writes 0xDEADBEEF to 0x020 (mem_esc=1 for exactly one cycle), then the core reads 0x020. Expect core_dat_lec=0xDEADBEEF.
- Simultaneous requests after reset: both requests high. Expect grant order core, cargador, core, cargador over 4 accesses, each access 3 cycles, no listo overlap.
- Reset while in CONCEDE with a core write: reset=1 for one cycle. Expect mem_esc=0, ocupado=0, no listo next cycle; RAM word unchanged.
- req dropped early: core_req deasserted during CONCEDE. Expect core_listo still pulses once, then REPOSO.
- With ARB_BLOQUEO_EN, cargador_bloqueo=1 and core_req=1 for 20 cycles, loader issuing 5 writes. Expect 5 cargador_listo pulses and no core_listo. Then clear cargador_bloqueo: expect core_listo within 3 cycles if the loader is idle.
